// File: rtl/zap_wb_ram_responder.sv
// Wishbone B3 classic responder over an internal word RAM with programmable wait states.
// Out-of-window addresses terminate with err; reads are registered on entry to RESP.
module zap_wb_ram_responder #(
   parameter int          DEPTH       = 1024,
   parameter logic [31:0] BASE_ADDR   = 32'h0,
   parameter int          WAIT_STATES = 0
) (
   input  logic        i_clk,
   input  logic        i_reset,
   input  logic        i_wb_cyc,
   input  logic        i_wb_stb,
   input  logic        i_wb_wen,
   input  logic [3:0]  i_wb_sel,
   input  logic [31:0] i_wb_adr,
   input  logic [31:0] i_wb_dat,
   output logic [31:0] o_wb_dat,
   output logic        o_wb_ack,
   output logic        o_wb_err
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [3:0]    cnt_q, cnt_d;
   logic [AW-1:0] idx_q;
   logic          wen_q;
   logic [3:0]    sel_q;
   logic [31:0]   wdat_q;
   logic          hit_q;
   logic [31:0]   rdat_q;
   logic          load_req;

   logic [31:0]   mem [DEPTH];

   logic          req;
   logic [29:0]   diff;
   logic          live_hit;
   logic [AW-1:0] live_idx;
   logic          enter_resp;
   logic [AW-1:0] rd_idx;
   logic          rd_hit;
   logic          unused_adr;

   assign req        = i_wb_cyc & i_wb_stb;
   assign diff       = i_wb_adr[31:2] - BASE_ADDR[31:2];
   assign live_hit   = ({1'b0, diff} < 31'(DEPTH));
   assign live_idx   = diff[AW-1:0];
   assign unused_adr = ^i_wb_adr[1:0];

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      load_req = 1'b0;
      o_wb_ack = 1'b0;
      o_wb_err = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               load_req = 1'b1;
               if (WAIT_STATES == 0) begin
                  state_d = S_RESP;
               end else begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end
            end
         end
         S_WAIT: begin
            if (!i_wb_cyc) begin
               state_d = S_IDLE;
            end else if (cnt_q == 4'd0) begin
               state_d = S_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            o_wb_ack = req & hit_q;
            o_wb_err = req & ~hit_q;
            state_d  = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // With zero wait states RESP is entered straight from IDLE, before the latch settles.
   assign enter_resp = (state_d == S_RESP) && (state_q != S_RESP);
   assign rd_idx     = (state_q == S_IDLE) ? live_idx : idx_q;
   assign rd_hit     = (state_q == S_IDLE) ? live_hit : hit_q;

   always_ff @(posedge i_clk) begin
      if (i_reset) begin
         state_q <= S_IDLE;
         cnt_q   <= 4'd0;
         idx_q   <= '0;
         wen_q   <= 1'b0;
         sel_q   <= 4'd0;
         wdat_q  <= 32'd0;
         hit_q   <= 1'b0;
         rdat_q  <= 32'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         if (load_req) begin
            idx_q  <= live_idx;
            wen_q  <= i_wb_wen;
            sel_q  <= i_wb_sel;
            wdat_q <= i_wb_dat;
            hit_q  <= live_hit;
         end
         if (enter_resp) begin
            rdat_q <= rd_hit ? mem[rd_idx] : 32'd0;
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset && o_wb_ack && wen_q) begin
         for (int n = 0; n < 4; n++) begin
            if (sel_q[n]) begin
               mem[idx_q][8*n +: 8] <= wdat_q[8*n +: 8];
            end
         end
      end
   end

   assign o_wb_dat = rdat_q;

endmodule

// File: tb/tb_zap_wb_ram_responder.sv
// Directed bench: three responders (0, 2, 3 wait states) share one bus, each with its own cyc.
module tb_zap_wb_ram_responder;

   localparam logic [31:0] BASE = 32'h0000_1000;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [2:0]  cyc = 3'b000;
   logic        stb = 1'b0;
   logic        wen = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = 32'd0;
   logic [31:0] wdat = 32'd0;
   logic [31:0] rdat [3];
   logic [2:0]  ack;
   logic [2:0]  err;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : g_dut
      zap_wb_ram_responder #(
         .DEPTH(64), .BASE_ADDR(BASE), .WAIT_STATES(g == 0 ? 0 : (g == 1 ? 2 : 3))
      ) u_dut (
         .i_clk(clk), .i_reset(rst), .i_wb_cyc(cyc[g]), .i_wb_stb(stb),
         .i_wb_wen(wen), .i_wb_sel(sel), .i_wb_adr(adr), .i_wb_dat(wdat),
         .o_wb_dat(rdat[g]), .o_wb_ack(ack[g]), .o_wb_err(err[g])
      );
   end

   typedef struct {
      logic        w;
      logic [3:0]  s;
      logic [31:0] a;
      logic [31:0] d;
      logic        ea;
      logic        ee;
      logic [31:0] ed;
   } vec_t;

   vec_t tab [16];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   // Latency is counted in cycles after the sampling cycle; -1 means no termination seen.
   task automatic xfer(input int k, input logic w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, input bit hold, output logic ak, output logic er,
                       output logic [31:0] rd, output int lat);
      @(posedge clk); #1;
      cyc[k] = 1'b1; stb = 1'b1; wen = w; sel = s; adr = a; wdat = d;
      ak = 1'b0; er = 1'b0; rd = 32'd0; lat = -1;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (ack[k] | err[k]) begin
            ak = ack[k]; er = err[k]; rd = rdat[k]; lat = n;
            break;
         end
      end
      if (hold && lat >= 0) begin
         @(negedge clk);
         chk("pulse_width", {30'd0, ack[k], err[k]}, 32'd0);
      end
      @(posedge clk); #1;
      cyc[k] = 1'b0; stb = 1'b0;
   endtask

   initial begin
      logic        ak, er;
      logic [31:0] rd;
      int          lat;
      logic [7:0]  pat;
      logic        seen;

      tab[0]  = '{1'b1, 4'hF, BASE + 32'h10,  32'hDEADBEEF, 1'b1, 1'b0, 32'h0};
      tab[1]  = '{1'b0, 4'hF, BASE + 32'h10,  32'h0,        1'b1, 1'b0, 32'hDEADBEEF};
      tab[2]  = '{1'b1, 4'h5, BASE + 32'h10,  32'h11223344, 1'b1, 1'b0, 32'h0};
      tab[3]  = '{1'b0, 4'hF, BASE + 32'h10,  32'h0,        1'b1, 1'b0, 32'hDE22BE44};
      tab[4]  = '{1'b1, 4'h0, BASE + 32'h10,  32'hFFFFFFFF, 1'b1, 1'b0, 32'h0};
      tab[5]  = '{1'b0, 4'hF, BASE + 32'h13,  32'h0,        1'b1, 1'b0, 32'hDE22BE44};
      tab[6]  = '{1'b1, 4'hF, BASE + 32'hFC,  32'hCAFEF00D, 1'b1, 1'b0, 32'h0};
      tab[7]  = '{1'b1, 4'hF, BASE + 32'h100, 32'h12345678, 1'b0, 1'b1, 32'h0};
      tab[8]  = '{1'b1, 4'hF, BASE - 32'h4,   32'h87654321, 1'b0, 1'b1, 32'h0};
      tab[9]  = '{1'b0, 4'hF, BASE + 32'h100, 32'h0,        1'b0, 1'b1, 32'h0};
      tab[10] = '{1'b0, 4'hF, BASE - 32'h4,   32'h0,        1'b0, 1'b1, 32'h0};
      tab[11] = '{1'b0, 4'hF, BASE + 32'hFC,  32'h0,        1'b1, 1'b0, 32'hCAFEF00D};
      tab[12] = '{1'b1, 4'hF, BASE,           32'h00000000, 1'b1, 1'b0, 32'h0};
      tab[13] = '{1'b1, 4'h8, BASE,           32'hAABBCCDD, 1'b1, 1'b0, 32'h0};
      tab[14] = '{1'b0, 4'hF, BASE,           32'h0,        1'b1, 1'b0, 32'hAA000000};
      tab[15] = '{1'b0, 4'h2, BASE + 32'h10,  32'h0,        1'b1, 1'b0, 32'hDE22BE44};

      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("reset_ack", {29'd0, ack}, 32'd0);
      chk("reset_err", {29'd0, err}, 32'd0);
      chk("reset_dat", rdat[0], 32'd0);

      for (int i = 0; i < 16; i++) begin
         xfer(0, tab[i].w, tab[i].s, tab[i].a, tab[i].d, 1'b0, ak, er, rd, lat);
         chk($sformatf("v%0d_ack", i), {31'd0, ak}, {31'd0, tab[i].ea});
         chk($sformatf("v%0d_err", i), {31'd0, er}, {31'd0, tab[i].ee});
         chk($sformatf("v%0d_lat", i), 32'(lat), 32'd1);
         if (!tab[i].w) chk($sformatf("v%0d_dat", i), rd, tab[i].ed);
      end

      // Four transfers with stb held: one ack every other cycle.
      @(posedge clk); #1;
      cyc[0] = 1'b1; stb = 1'b1; wen = 1'b0; sel = 4'hF; adr = BASE + 32'h10;
      pat = 8'd0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         pat[k] = ack[0];
      end
      @(posedge clk); #1;
      cyc[0] = 1'b0; stb = 1'b0;
      chk("b2b_pattern", {24'd0, pat}, 32'h000000AA);
      chk("b2b_dat", rdat[0], 32'hDE22BE44);

      // Three wait states: write, then read with cyc held past the ack.
      xfer(2, 1'b1, 4'hF, BASE + 32'h20, 32'h01020304, 1'b0, ak, er, rd, lat);
      chk("ws3_wr_lat", 32'(lat), 32'd4);
      chk("ws3_wr_ack", {31'd0, ak}, 32'd1);
      xfer(2, 1'b0, 4'hF, BASE + 32'h20, 32'h0, 1'b1, ak, er, rd, lat);
      chk("ws3_rd_lat", 32'(lat), 32'd4);
      chk("ws3_rd_ack", {31'd0, ak}, 32'd1);
      chk("ws3_rd_err", {31'd0, er}, 32'd0);
      chk("ws3_rd_dat", rd, 32'h01020304);

      // Two wait states: abort a write by dropping cyc in WAIT.
      xfer(1, 1'b1, 4'hF, BASE + 32'h44, 32'hA0B0C0D0, 1'b0, ak, er, rd, lat);
      chk("ws2_wr_lat", 32'(lat), 32'd3);
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb = 1'b1; wen = 1'b1; sel = 4'hF; adr = BASE + 32'h44; wdat = 32'h5A5A5A5A;
      @(posedge clk); #1;
      cyc[1] = 1'b0; stb = 1'b0;
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         seen = seen | ack[1] | err[1];
      end
      chk("abort_no_term", {31'd0, seen}, 32'd0);
      xfer(1, 1'b0, 4'hF, BASE + 32'h44, 32'h0, 1'b0, ak, er, rd, lat);
      chk("abort_old_dat", rd, 32'hA0B0C0D0);

      // Reset while in WAIT after a read left nonzero data on the bus.
      xfer(1, 1'b1, 4'hF, BASE + 32'h40, 32'h13579BDF, 1'b0, ak, er, rd, lat);
      xfer(1, 1'b0, 4'hF, BASE + 32'h40, 32'h0, 1'b0, ak, er, rd, lat);
      chk("pre_rst_dat", rd, 32'h13579BDF);
      @(posedge clk); #1;
      cyc[1] = 1'b1; stb = 1'b1; wen = 1'b0; sel = 4'hF; adr = BASE + 32'h40;
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0; cyc[1] = 1'b0; stb = 1'b0;
      @(negedge clk);
      chk("mid_rst_dat", rdat[1], 32'd0);
      chk("mid_rst_term", {30'd0, ack[1], err[1]}, 32'd0);
      xfer(1, 1'b0, 4'hF, BASE + 32'h40, 32'h0, 1'b0, ak, er, rd, lat);
      chk("post_rst_lat", 32'(lat), 32'd3);
      chk("post_rst_dat", rd, 32'h13579BDF);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
